fir_core: RTL and testbench

FIR_CORE -- requirements
Module: fir_core

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_sample_fifo.sv | 78 +++++++
 rtl/fir_core.sv | 158 +++++++++++++++
 tb/tb_fir_core.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and types for the FIR filter slice.
//   NTAPS      - number of filter taps (coefficients / delay-line entries)
//   DW         - sample and coefficient width, signed Q1.15
//   ACCW       - accumulator width; 64 full-scale 32-bit products fit without overflow
//   FIFO_DEPTH - entries in the input sample FIFO
//   engine_state_t - IDLE (waiting for a sample), MAC (one tap per cycle), OUT (result)
package fir_pkg;

  localparam int NTAPS      = 64;
  localparam int DW         = 16;
  localparam int ACCW       = 40;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } engine_state_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo: synchronous single-clock FIFO for input samples.
// Ports:
//   clk2    - processing clock, rising edge
//   rstn    - synchronous active-low reset, empties the FIFO
//   push    - write strobe; ignored while full
//   pop     - read strobe; ignored while empty
//   wr_data - sample to write
//   rd_data - head of the FIFO (show-ahead, valid whenever empty=0)
//   empty   - registered, exact empty flag
//   full    - registered, exact full flag (DEPTH entries)
module fir_sample_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic          clk2,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          do_push;
  logic          do_pop;

  // A push while full is dropped outright, so the flags gate the strobes.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Flags are computed from the next occupancy so they stay registered yet exact.
  always_ff @(posedge clk2) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == (AW+1)'(DEPTH));
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk2) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/fir_core.sv
// fir_core: time-multiplexed FIR filter, one multiply-accumulate per cycle.
// Ports:
//   clk2       - processing clock, rising edge
//   rstn       - synchronous active-low reset
//   din        - signed Q1.15 input sample
//   valid_in   - push strobe for din into the input FIFO
//   cload      - coefficient write enable; also holds off new samples
//   caddr      - coefficient address
//   cin        - signed Q1.15 coefficient write data
//   dout       - saturated signed filter result, held between results
//   valid_out  - one-cycle strobe marking a new dout
//   fifo_empty - input FIFO empty flag
//   fifo_full  - input FIFO full flag
module fir_core #(
  parameter int NTAPS      = fir_pkg::NTAPS,
  parameter int DW         = fir_pkg::DW,
  parameter int FIFO_DEPTH = fir_pkg::FIFO_DEPTH
) (
  input  logic                     clk2,
  input  logic                     rstn,
  input  logic [DW-1:0]            din,
  input  logic                     valid_in,
  input  logic                     cload,
  input  logic [$clog2(NTAPS)-1:0] caddr,
  input  logic [DW-1:0]            cin,
  output logic [DW-1:0]            dout,
  output logic                     valid_out,
  output logic                     fifo_empty,
  output logic                     fifo_full
);

  import fir_pkg::*;

  localparam int AW = $clog2(NTAPS);
  localparam int PW = 2 * DW;

  // Q1.15 products accumulate as Q(x).30; shifting by DW-1 returns to Q1.15.
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((64'sd1 <<< (DW-1)) - 64'sd1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [DW-1:0]   coeff [NTAPS];
  logic signed [DW-1:0]   dline [NTAPS];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          cur_ptr;
  logic [AW-1:0]          tap_idx;
  logic [AW-1:0]          rd_idx;
  logic signed [PW-1:0]   product;
  logic signed [ACCW-1:0] acc;
  logic [DW-1:0]          fifo_data;
  engine_state_t          state;
  engine_state_t          state_next;
  logic                   pop;
  logic                   mac_en;
  logic                   out_en;

  function automatic logic [DW-1:0] saturate(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    s = a >>> (DW-1);
    if (s > SAT_MAX) begin
      return SAT_MAX[DW-1:0];
    end else if (s < SAT_MIN) begin
      return SAT_MIN[DW-1:0];
    end
    return s[DW-1:0];
  endfunction

  fir_sample_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk2    (clk2),
    .rstn    (rstn),
    .push    (valid_in),
    .pop     (pop),
    .wr_data (din),
    .rd_data (fifo_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Walk backwards through the circular delay line from the newest sample;
  // the subtraction wraps naturally because NTAPS is a power of two.
  assign rd_idx  = cur_ptr - tap_idx;
  assign product = PW'(coeff[tap_idx]) * PW'(dline[rd_idx]);

  always_ff @(posedge clk2) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // cload only holds off the start of a new frame; a frame in MAC runs to completion.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (!fifo_empty && !cload) state_next = ST_MAC;
      ST_MAC:  if (tap_idx == AW'(NTAPS-1)) state_next = ST_OUT;
      ST_OUT:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pop    = (state == ST_IDLE) && !fifo_empty && !cload;
    mac_en = (state == ST_MAC);
    out_en = (state == ST_OUT);
  end

  // Coefficient and delay-line register arrays; both are zeroed by reset so the
  // first outputs after reset see an all-zero history.
  always_ff @(posedge clk2) begin
    if (!rstn) begin
      for (int i = 0; i < NTAPS; i++) begin
        coeff[i] <= '0;
        dline[i] <= '0;
      end
    end else begin
      if (cload) begin
        coeff[caddr] <= cin;
      end
      if (pop) begin
        dline[wr_ptr] <= fifo_data;
      end
    end
  end

  // Datapath: on a pop remember where x[n] landed and clear the accumulator,
  // then add one tap per MAC cycle, and publish the saturated result in OUT.
  always_ff @(posedge clk2) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      cur_ptr   <= '0;
      tap_idx   <= '0;
      acc       <= '0;
      dout      <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (pop) begin
        cur_ptr <= wr_ptr;
        wr_ptr  <= wr_ptr + AW'(1);
        tap_idx <= '0;
        acc     <= '0;
      end
      if (mac_en) begin
        acc     <= acc + ACCW'(product);
        tap_idx <= tap_idx + AW'(1);
      end
      if (out_en) begin
        dout      <= saturate(acc);
        valid_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_core.sv
// tb_fir_core: self-checking bench for fir_core.
// The reference model is a direct convolution over every sample accepted since
// reset: y[n] = sat(floor(sum_k c[k]*x[n-k] / 2^15)), with x before reset = 0.
module tb_fir_core;

  localparam int NT = 64;

  logic        clk2 = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] din = '0;
  logic        valid_in = 1'b0;
  logic        cload = 1'b0;
  logic [5:0]  caddr = '0;
  logic [15:0] cin = '0;
  logic [15:0] dout;
  logic        valid_out;
  logic        fifo_empty;
  logic        fifo_full;

  fir_core dut (
    .clk2       (clk2),
    .rstn       (rstn),
    .din        (din),
    .valid_in   (valid_in),
    .cload      (cload),
    .caddr      (caddr),
    .cin        (cin),
    .dout       (dout),
    .valid_out  (valid_out),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  always #5 clk2 = ~clk2;

  int cyc = 0;
  always @(posedge clk2) cyc <= cyc + 1;

  // Every valid_out pulse is captured with its cycle stamp.
  logic [15:0] obs_dout [2048];
  int          obs_cyc  [2048];
  int          obs_cnt = 0;
  always @(negedge clk2) begin
    if (valid_out === 1'b1) begin
      if (obs_cnt < 2048) begin
        obs_dout[obs_cnt] <= dout;
        obs_cyc[obs_cnt]  <= cyc;
      end
      obs_cnt <= obs_cnt + 1;
    end
  end

  shortint     coef_m [NT];
  shortint     hist [$];
  logic [15:0] exp_q [$];
  int          exp_total = 0;
  int          chk_ptr = 0;
  int          vectors = 0;
  int          miscompares = 0;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached, observed %0d results, expected %0d", obs_cnt, exp_total);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] modelResult();
    longint sum;
    int     n;
    sum = 0;
    n   = hist.size();
    for (int k = 0; k < NT; k++) begin
      if (n - 1 - k >= 0) sum += longint'(coef_m[k]) * longint'(hist[n-1-k]);
    end
    sum = sum >>> 15;
    if (sum > 32767) return 16'h7FFF;
    if (sum < -32768) return 16'h8000;
    return sum[15:0];
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NT; k++) coef_m[k] = 0;
    hist.delete();
    exp_total -= exp_q.size();
    exp_q.delete();
  endtask

  task automatic doReset();
    rstn     = 1'b0;
    valid_in = 1'b0;
    cload    = 1'b0;
    tick();
    tick();
    modelReset();
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_valid_out", valid_out, 0);
    checkOutput("rst_fifo_empty", fifo_empty, 1);
    checkOutput("rst_fifo_full", fifo_full, 0);
    rstn = 1'b1;
  endtask

  task automatic loadCoeffs(input shortint vals[NT]);
    cload = 1'b1;
    for (int k = 0; k < NT; k++) begin
      caddr     = 6'(k);
      cin       = vals[k];
      coef_m[k] = vals[k];
      tick();
    end
    cload = 1'b0;
  endtask

  task automatic applyStimulus(input shortint sample, input bit accepted);
    valid_in = 1'b1;
    din      = sample;
    tick();
    valid_in = 1'b0;
    if (accepted) begin
      hist.push_back(sample);
      exp_q.push_back(modelResult());
      exp_total++;
    end
  endtask

  // Waits for every outstanding result, compares them in order, then checks
  // that no extra pulse follows and that dout holds the last result.
  task automatic waitResults(input string tag);
    int          budget;
    logic [15:0] last;
    bit          had;
    budget = 70 * (exp_q.size() + 1) + 20;
    had    = 1'b0;
    last   = '0;
    while (obs_cnt < exp_total && budget > 0) begin
      tick();
      budget--;
    end
    if (obs_cnt < exp_total) checkOutput({tag, "_timeout"}, obs_cnt, exp_total);
    while (exp_q.size() > 0 && chk_ptr < obs_cnt) begin
      last = exp_q.pop_front();
      had  = 1'b1;
      checkOutput(tag, obs_dout[chk_ptr], last);
      chk_ptr++;
    end
    exp_total -= exp_q.size();
    exp_q.delete();
    repeat (3) tick();
    checkOutput({tag, "_count"}, obs_cnt, exp_total);
    if (had) checkOutput({tag, "_hold"}, dout, last);
  endtask

  // Pushes in bursts (fixed size, or random 1..8 when maxb is 0), draining between bursts.
  task automatic pushSeq(input shortint q[$], input int maxb, input string tag);
    int i;
    int n;
    i = 0;
    while (i < q.size()) begin
      n = (maxb == 0) ? int'($urandom_range(1, 8)) : maxb;
      for (int j = 0; j < n && i < q.size(); j++) begin
        applyStimulus(q[i], 1'b1);
        i++;
      end
      waitResults(tag);
    end
  endtask

  initial begin
    shortint q [$];
    shortint cv [NT];
    int      base;
    int      push_cyc;

    $display("[TB] tb_fir_core starting");
    doReset();

    // Impulse response reproduces the coefficient ramp scaled by 0.5.
    for (int k = 0; k < NT; k++) cv[k] = shortint'((k + 1) * 256);
    loadCoeffs(cv);
    q.delete();
    q.push_back(shortint'(16'h4000));
    for (int k = 0; k < 70; k++) q.push_back(0);
    base = chk_ptr;
    pushSeq(q, 8, "impulse");
    checkOutput("impulse_first", obs_dout[base], 16'h0080);
    checkOutput("impulse_63", obs_dout[base + 63], 16'h2000);
    checkOutput("impulse_64", obs_dout[base + 64], 16'h0000);

    // Pop-to-valid_out latency of a lone sample.
    applyStimulus(shortint'(16'h1000), 1'b1);
    push_cyc = cyc;
    waitResults("latency_val");
    checkOutput("latency", obs_cyc[chk_ptr - 1] - push_cyc, 66);

    // DC input ramps up to 0x4000 at the 64th result and stays there.
    doReset();
    for (int k = 0; k < NT; k++) cv[k] = shortint'(16'h0200);
    loadCoeffs(cv);
    q.delete();
    for (int k = 0; k < 70; k++) q.push_back(shortint'(16'h4000));
    base = chk_ptr;
    pushSeq(q, 8, "dc");
    checkOutput("dc_63rd", obs_dout[base + 62], 16'h3F00);
    checkOutput("dc_64th", obs_dout[base + 63], 16'h4000);
    checkOutput("dc_final", dout, 16'h4000);

    // Saturation at both rails.
    doReset();
    for (int k = 0; k < NT; k++) cv[k] = shortint'(16'h7FFF);
    loadCoeffs(cv);
    q.delete();
    for (int k = 0; k < 64; k++) q.push_back(shortint'(16'h7FFF));
    pushSeq(q, 8, "sat_pos");
    checkOutput("sat_pos_final", dout, 16'h7FFF);
    q.delete();
    for (int k = 0; k < 64; k++) q.push_back(shortint'(16'h8000));
    pushSeq(q, 8, "sat_neg");
    checkOutput("sat_neg_final", dout, 16'h8000);

    // FIFO fill while cload holds the engine off; cload rewrites coeff[0] unchanged.
    cload = 1'b1;
    caddr = 6'd0;
    cin   = coef_m[0];
    for (int i = 0; i < 9; i++) begin
      applyStimulus(shortint'($urandom_range(0, 65535)), i < 8);
      if (i == 6) checkOutput("fifo_full_at7", fifo_full, 0);
      if (i == 7) begin
        checkOutput("fifo_full_at8", fifo_full, 1);
        checkOutput("fifo_empty_at8", fifo_empty, 0);
      end
      if (i == 8) checkOutput("fifo_full_at9", fifo_full, 1);
    end
    repeat (5) tick();
    checkOutput("fifo_held", fifo_full, 1);
    cload = 1'b0;
    base  = chk_ptr;
    waitResults("fifo");
    for (int i = 1; i < 8; i++) begin
      checkOutput("fifo_spacing", obs_cyc[base + i] - obs_cyc[base + i - 1], 66);
    end
    checkOutput("fifo_empty_end", fifo_empty, 1);

    // Reset in MAC cycle 30 aborts the frame silently.
    applyStimulus(shortint'(16'h2345), 1'b1);
    repeat (30) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checkOutput("midrst_dout", dout, 0);
    checkOutput("midrst_valid_out", valid_out, 0);
    checkOutput("midrst_fifo_empty", fifo_empty, 1);
    checkOutput("midrst_fifo_full", fifo_full, 0);
    modelReset();
    repeat (80) tick();
    checkOutput("midrst_no_valid", obs_cnt, exp_total);

    // Coefficients were cleared by that reset, so results are zero.
    q.delete();
    for (int k = 0; k < 3; k++) q.push_back(shortint'(16'h4000));
    pushSeq(q, 8, "coef_cleared");

    // Random coefficients and samples in random bursts, then a coefficient reload.
    doReset();
    for (int k = 0; k < NT; k++) cv[k] = shortint'($urandom_range(0, 65535));
    loadCoeffs(cv);
    q.delete();
    for (int k = 0; k < 40; k++) q.push_back(shortint'($urandom_range(0, 65535)));
    pushSeq(q, 0, "rand1");
    for (int k = 0; k < NT; k++) cv[k] = shortint'($urandom_range(0, 8191));
    loadCoeffs(cv);
    q.delete();
    for (int k = 0; k < 16; k++) q.push_back(shortint'($urandom_range(0, 65535)));
    pushSeq(q, 0, "rand2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
